ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 29 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

  // Access sequencer states: wait for a grant, drive the RAM, return the response.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Requester ids, also used as the last-served pointer value.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // One requester's command as seen on its port group.
  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Word index (addr[30:2]) inside a RAM of the given depth.
  function automatic logic word_in_range(input logic [28:0] word_idx,
                                         input int unsigned words);
    return {3'b000, word_idx} < words;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins; on a tie the requester
// that was not served last wins. Purely combinational.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // Grant selection from the request pair and the last-served pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == M0) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester front end for a single-port 32-bit RAM. One access at a time:
// accept in IDLE, drive the RAM for one ACCESS cycle, strobe the owner's
// response in RESP. Fixed latency 2, one access per 3 cycles.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_rsp,
  output logic        m0_err,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_rsp,
  output logic        m1_err,
  output logic [31:0] rsp_rdata,
  output logic        ram_r,
  output logic [3:0]  ram_w,
  output logic [31:0] ram_in,
  output logic [31:0] ram_addr,
  input  logic [31:0] ram_out
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;
  logic        r_owner;
  logic        r_we;
  logic [3:0]  r_be;
  logic        r_err;
  logic [31:0] r_ram_addr;
  logic [31:0] r_ram_in;
  logic [31:0] r_rsp_rdata;

  logic [1:0]  w_grant;
  logic        w_accept;
  logic        w_sel_owner;
  req_t        w_sel;
  logic        w_sel_oor;
  logic        w_drive;

  rr_arb2 u_rr_arb2 (
    .req   ({m1_valid, m0_valid}),
    .last  (r_last),
    .grant (w_grant)
  );

  // A handshake happens only in IDLE; the arbiter already gates grant by valid.
  assign w_accept    = (r_state == IDLE) && (w_grant != 2'b00);
  assign w_sel_owner = w_grant[1] ? M1 : M0;
  assign w_sel_oor   = !word_in_range(w_sel.addr[30:2], WORDS);

  // Route the granted requester's command to the capture registers.
  always_comb begin
    w_sel = '{we: m0_we, be: m0_be, addr: m0_addr, wdata: m0_wdata};
    if (w_grant[1]) begin
      w_sel = '{we: m1_we, be: m1_be, addr: m1_addr, wdata: m1_wdata};
    end
  end

  // Ready is forced low while reset is held, even though the state is already IDLE.
  assign m0_ready = rst_n && (r_state == IDLE) && w_grant[0];
  assign m1_ready = rst_n && (r_state == IDLE) && w_grant[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: IDLE waits for an accept, the other two states last one cycle each.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the granted command and advance the round-robin pointer on accept.
  // The RAM address/data registers move only for in-range requests so the RAM
  // pins keep their previous values when an out-of-range request is served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= M1;
      r_owner    <= M0;
      r_we       <= 1'b0;
      r_be       <= 4'b0;
      r_err      <= 1'b0;
      r_ram_addr <= '0;
      r_ram_in   <= '0;
    end else if (w_accept) begin
      r_last  <= w_sel_owner;
      r_owner <= w_sel_owner;
      r_we    <= w_sel.we;
      r_be    <= w_sel.be;
      r_err   <= w_sel_oor;
      if (!w_sel_oor) begin
        r_ram_addr <= w_sel.addr;
        r_ram_in   <= w_sel.wdata;
      end
    end
  end

  // RAM strobes are live only during ACCESS of an in-range request; the write
  // itself lands on the RAM's falling edge inside that cycle.
  assign w_drive  = (r_state == ACCESS) && !r_err;
  assign ram_r    = w_drive && !r_we;
  assign ram_w    = (w_drive && r_we) ? r_be : 4'b0;
  assign ram_addr = r_ram_addr;
  assign ram_in   = r_ram_in;

  // Response data: RAM output for in-range reads, zero for writes and errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata <= '0;
    end else if (r_state == ACCESS) begin
      r_rsp_rdata <= (!r_err && !r_we) ? ram_out : 32'h0;
    end
  end

  assign rsp_rdata = r_rsp_rdata;
  assign m0_rsp    = (r_state == RESP) && (r_owner == M0);
  assign m1_rsp    = (r_state == RESP) && (r_owner == M1);
  assign m0_err    = m0_rsp && r_err;
  assign m1_err    = m1_rsp && r_err;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed table, arbitration and reset
// sequences, then randomized traffic against a word-array reference model.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int WORDS = 32;
  localparam int AW    = $clog2(WORDS);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_valid, m0_ready, m0_we, m0_rsp, m0_err;
  logic [3:0]  m0_be;
  logic [31:0] m0_addr, m0_wdata;
  logic        m1_valid, m1_ready, m1_we, m1_rsp, m1_err;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr, m1_wdata;
  logic [31:0] rsp_rdata;
  logic        ram_r;
  logic [3:0]  ram_w;
  logic [31:0] ram_in, ram_addr, ram_out;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: memory image and last-served requester.
  logic [31:0] ref_mem [WORDS];
  logic        model_last;

  // RAM attached to the DUT: combinational read, byte writes on the falling edge.
  logic [31:0] ram_mem [WORDS];

  always #5 clk = ~clk;

  ram_arbiter #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_valid  (m0_valid),
    .m0_ready  (m0_ready),
    .m0_we     (m0_we),
    .m0_be     (m0_be),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_rsp    (m0_rsp),
    .m0_err    (m0_err),
    .m1_valid  (m1_valid),
    .m1_ready  (m1_ready),
    .m1_we     (m1_we),
    .m1_be     (m1_be),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_rsp    (m1_rsp),
    .m1_err    (m1_err),
    .rsp_rdata (rsp_rdata),
    .ram_r     (ram_r),
    .ram_w     (ram_w),
    .ram_in    (ram_in),
    .ram_addr  (ram_addr),
    .ram_out   (ram_out)
  );

  assign ram_out = ram_mem[ram_addr[AW+1:2]];

  always @(negedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_w[b]) ram_mem[ram_addr[AW+1:2]][8*b +: 8] <= ram_in[8*b +: 8];
    end
  end

  typedef struct {
    bit          m;
    req_t        r;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return int'(a[30:2]) < WORDS;
  endfunction

  function automatic req_t rand_req();
    req_t        r;
    int unsigned word;
    word    = $urandom_range(0, WORDS + 3);
    r.we    = 1'($urandom_range(0, 1));
    r.be    = 4'($urandom);
    r.wdata = $urandom;
    r.addr  = {1'($urandom_range(0, 1)), 29'(word), 2'($urandom_range(0, 3))};
    return r;
  endfunction

  function automatic void model_write(input req_t r);
    for (int b = 0; b < 4; b++) begin
      if (r.be[b]) ref_mem[r.addr[AW+1:2]][8*b +: 8] = r.wdata[8*b +: 8];
    end
  endfunction

  task automatic drive(input bit v0, input bit v1, input req_t r0, input req_t r1);
    m0_valid = v0; m0_we = r0.we; m0_be = r0.be; m0_addr = r0.addr; m0_wdata = r0.wdata;
    m1_valid = v1; m1_we = r1.we; m1_be = r1.be; m1_addr = r1.addr; m1_wdata = r1.wdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    model_last = M1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete transaction: present requests, wait for the handshake, then
  // check the ACCESS cycle (RAM pins) and the RESP cycle (strobe, err, data).
  task automatic issue(input string tag, input bit v0, input bit v1,
                       input req_t r0, input req_t r1, input bit exp_own,
                       input logic [31:0] exp_rdata, input bit exp_err);
    req_t       w;
    bit         got;
    bit         inr;
    logic [1:0] exp_sel;
    w       = exp_own ? r1 : r0;
    inr     = in_rng(w.addr);
    exp_sel = exp_own ? 2'b10 : 2'b01;
    @(negedge clk);
    drive(v0, v1, r0, r1);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (m0_ready || m1_ready) got = 1'b1;
      else @(negedge clk);
    end
    check({tag, " handshake"}, 32'(got), 32'd1);
    if (!got) begin
      drive(1'b0, 1'b0, '0, '0);
      return;
    end
    check({tag, " ready"}, {30'd0, m1_ready, m0_ready}, {30'd0, exp_sel});
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, rand_req(), rand_req());
    @(negedge clk);
    check({tag, " rsp in access"}, {30'd0, m1_rsp, m0_rsp}, 32'd0);
    check({tag, " ram_r"}, 32'(ram_r), 32'(!w.we && inr));
    check({tag, " ram_w"}, {28'd0, ram_w}, (w.we && inr) ? {28'd0, w.be} : 32'd0);
    if (inr) begin
      check({tag, " ram_addr"}, ram_addr, w.addr);
      if (w.we) check({tag, " ram_in"}, ram_in, w.wdata);
    end
    @(negedge clk);
    check({tag, " rsp"}, {30'd0, m1_rsp, m0_rsp}, {30'd0, exp_sel});
    check({tag, " err"}, {30'd0, m1_err, m0_err}, exp_err ? {30'd0, exp_sel} : 32'd0);
    check({tag, " rdata"}, rsp_rdata, exp_rdata);
    check({tag, " ram idle in resp"}, {27'd0, ram_r, ram_w}, 32'd0);
    model_last = exp_own;
    if (w.we && inr) model_write(w);
  endtask

  // Arbitration sequence scratch.
  int   ng;
  int   cyc;
  bit   own_q [4];
  int   cyc_q [4];
  bit   exp_o;
  bit   got_rdy;
  bit   seen_rsp;
  req_t ra, rb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      ram_mem[i] <= 32'h0;
      ref_mem[i] = 32'h0;
    end
    model_last = M1;

    tbl[0]  = '{m: 1'b0, r: '{we: 1'b1, be: 4'hF, addr: 32'h0000_0008, wdata: 32'hDEAD_BEEF}, exp_rdata: 32'h0,         exp_err: 1'b0};
    tbl[1]  = '{m: 1'b0, r: '{we: 1'b0, be: 4'h0, addr: 32'h0000_0008, wdata: 32'h0},         exp_rdata: 32'hDEAD_BEEF, exp_err: 1'b0};
    tbl[2]  = '{m: 1'b0, r: '{we: 1'b1, be: 4'hF, addr: 32'h0000_0004, wdata: 32'hFFFF_FFFF}, exp_rdata: 32'h0,         exp_err: 1'b0};
    tbl[3]  = '{m: 1'b1, r: '{we: 1'b1, be: 4'h3, addr: 32'h0000_0004, wdata: 32'h1234_5678}, exp_rdata: 32'h0,         exp_err: 1'b0};
    tbl[4]  = '{m: 1'b1, r: '{we: 1'b0, be: 4'h0, addr: 32'h0000_0004, wdata: 32'h0},         exp_rdata: 32'hFFFF_5678, exp_err: 1'b0};
    tbl[5]  = '{m: 1'b1, r: '{we: 1'b0, be: 4'hF, addr: 32'h0000_0080, wdata: 32'h0},         exp_rdata: 32'h0,         exp_err: 1'b1};
    tbl[6]  = '{m: 1'b0, r: '{we: 1'b1, be: 4'hF, addr: 32'h8000_0008, wdata: 32'h1111_1111}, exp_rdata: 32'h0,         exp_err: 1'b0};
    tbl[7]  = '{m: 1'b0, r: '{we: 1'b0, be: 4'h0, addr: 32'h0000_000B, wdata: 32'h0},         exp_rdata: 32'h1111_1111, exp_err: 1'b0};
    tbl[8]  = '{m: 1'b1, r: '{we: 1'b1, be: 4'h0, addr: 32'h0000_0008, wdata: 32'h0},         exp_rdata: 32'h0,         exp_err: 1'b0};
    tbl[9]  = '{m: 1'b1, r: '{we: 1'b0, be: 4'h0, addr: 32'h0000_0008, wdata: 32'h0},         exp_rdata: 32'h1111_1111, exp_err: 1'b0};
    tbl[10] = '{m: 1'b0, r: '{we: 1'b1, be: 4'hF, addr: 32'h0000_007C, wdata: 32'hCAFE_F00D}, exp_rdata: 32'h0,         exp_err: 1'b0};
    tbl[11] = '{m: 1'b0, r: '{we: 1'b0, be: 4'h0, addr: 32'h0000_007C, wdata: 32'h0},         exp_rdata: 32'hCAFE_F00D, exp_err: 1'b0};
    tbl[12] = '{m: 1'b0, r: '{we: 1'b1, be: 4'hF, addr: 32'h0000_0084, wdata: 32'h5555_5555}, exp_rdata: 32'h0,         exp_err: 1'b1};

    // Reset state, with both valids high to show ready is held low.
    drive(1'b1, 1'b1, '0, '0);
    rst_n = 1'b0;
    #12;
    check("reset ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    check("reset rsp/err", {28'd0, m1_rsp, m0_rsp, m1_err, m0_err}, 32'd0);
    check("reset ram strobes", {27'd0, ram_r, ram_w}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset ram_addr", ram_addr, 32'd0);
    do_reset();

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].m) issue($sformatf("vec%0d", i), 1'b0, 1'b1, '0, tbl[i].r, 1'b1, tbl[i].exp_rdata, tbl[i].exp_err);
      else          issue($sformatf("vec%0d", i), 1'b1, 1'b0, tbl[i].r, '0, 1'b0, tbl[i].exp_rdata, tbl[i].exp_err);
    end

    // Both requesters valid continuously: alternating grants, one every 3 cycles.
    do_reset();
    ra = '{we: 1'b0, be: 4'hF, addr: 32'h0, wdata: 32'h0};
    rb = '{we: 1'b0, be: 4'hF, addr: 32'h4, wdata: 32'h0};
    @(negedge clk);
    drive(1'b1, 1'b1, ra, rb);
    ng  = 0;
    cyc = 0;
    while (ng < 4 && cyc < 40) begin
      #1;
      if (m0_ready || m1_ready) begin
        own_q[ng] = m1_ready;
        cyc_q[ng] = cyc;
        ng++;
      end
      @(negedge clk);
      cyc++;
    end
    drive(1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check("rr grant count", 32'(ng), 32'd4);
    for (int i = 0; i < ng; i++) begin
      exp_o = !model_last;
      check($sformatf("rr grant%0d owner", i), 32'(own_q[i]), 32'(exp_o));
      model_last = exp_o;
      if (i > 0) check($sformatf("rr grant%0d spacing", i), 32'(cyc_q[i] - cyc_q[i-1]), 32'd3);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      req_t        a, b, w;
      int          pat;
      bit          own, ee;
      logic [31:0] er;
      a   = rand_req();
      b   = rand_req();
      pat = $urandom_range(1, 3);
      own = (pat == 3) ? !model_last : (pat == 2);
      w   = own ? b : a;
      ee  = !in_rng(w.addr);
      er  = (!w.we && !ee) ? ref_mem[w.addr[AW+1:2]] : 32'h0;
      issue($sformatf("rnd%0d", n), pat[0], pat[1], a, b, own, er, ee);
    end

    // Reset dropped during ACCESS of a write.
    @(negedge clk);
    drive(1'b1, 1'b0, '{we: 1'b1, be: 4'hF, addr: 32'h10, wdata: 32'hA5A5_A5A5}, '0);
    got_rdy = 1'b0;
    for (int c = 0; c < 20 && !got_rdy; c++) begin
      #1;
      if (m0_ready) got_rdy = 1'b1;
      else @(negedge clk);
    end
    check("midrst handshake", 32'(got_rdy), 32'd1);
    @(posedge clk);
    #2;
    drive(1'b1, 1'b1, '0, '0);
    rst_n = 1'b0;
    #1;
    check("midrst ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    check("midrst rsp/err", {28'd0, m1_rsp, m0_rsp, m1_err, m0_err}, 32'd0);
    check("midrst ram strobes", {27'd0, ram_r, ram_w}, 32'd0);
    check("midrst rsp_rdata", rsp_rdata, 32'd0);
    check("midrst ram_addr", ram_addr, 32'd0);
    check("midrst ram_in", ram_in, 32'd0);
    drive(1'b0, 1'b0, '0, '0);
    model_last = M1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_rsp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (m0_rsp || m1_rsp) seen_rsp = 1'b1;
    end
    check("midrst no rsp", 32'(seen_rsp), 32'd0);
    issue("postrst tie", 1'b1, 1'b1,
          '{we: 1'b0, be: 4'hF, addr: 32'h8, wdata: 32'h0},
          '{we: 1'b0, be: 4'hF, addr: 32'hC, wdata: 32'h0},
          M0, ref_mem[2], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
